// File: rtl/vsbc_pkg.sv
// Shared types and helpers for the vsbc run controller.
package vsbc_pkg;

  // Default maximum log2 run length (runs of up to 16 bits).
  localparam int VSBC_LMAX_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } vsbc_ctrl_state_e;

  // True for 1, 2, 4, 8, ...; zero is not a power of two.
  function automatic logic is_pow2(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/vsbc_ctrl_if.sv
// Command, bit-stream and result signals of the vsbc run controller.
interface vsbc_ctrl_if #(
  parameter int W    = 6,
  parameter int TW   = 16,
  parameter int LMAX = 4
);
  localparam int LW = $clog2(LMAX + 1);

  logic          start;
  logic [LW-1:0] len_log2;
  logic [W-1:0]  k_init;
  logic          z_valid;
  logic          z;
  logic          z_last;
  logic          z_ready;
  logic          busy;
  logic          done;
  logic [TW-1:0] result;
  logic [LMAX:0] res_len;
  logic          err;

  modport master (
    output start, len_log2, k_init, z_valid, z, z_last,
    input  z_ready, busy, done, result, res_len, err
  );

  modport slave (
    input  start, len_log2, k_init, z_valid, z, z_last,
    output z_ready, busy, done, result, res_len, err
  );
endinterface

// File: rtl/vsbc.sv
// Scaled bitstream counter. Each cycle the accumulator is optionally halved
// (rshift) and then the scale k_init is added if z is set:
//   bz <= (rshift ? bz >> 1 : bz) + (z ? k_init : 0)
// z=0, rshift=0 leaves the state untouched. The scale is held stable by the
// controller for the whole run; the clear (rst_n) zeroes the accumulator.
module vsbc #(
  parameter int W  = 6,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  k_init,
  input  logic          z,
  input  logic          rshift,
  output logic [TW-1:0] bz
);
  logic [TW-1:0] bz_q;

  // Accumulate scaled bits, halving on each scheduled shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bz_q <= '0;
    end else if (rshift || z) begin
      bz_q <= (rshift ? (bz_q >> 1) : bz_q) + (z ? TW'(k_init) : '0);
    end
  end

  assign bz = bz_q;
endmodule

// File: rtl/vsbc_ctrl.sv
// Run controller for the vsbc scaled bitstream counter.
// Optional early termination on z_last: define VSBC_CTRL_ET_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start, no bits accepted
// ST_CLEAR | one-cycle clear of vsbc, beat index reset
// ST_RUN   | accepting bits, rshift at power-of-two beat indices
// ST_FLUSH | final shift (index N), no bit
// ST_DONE  | latch Bz/length/err, raise done next cycle
module vsbc_ctrl
  import vsbc_pkg::*;
#(
  parameter int W    = 6,
  parameter int TW   = 16,
  parameter int LMAX = VSBC_LMAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  vsbc_ctrl_if.slave bus
);
  localparam int LW = $clog2(LMAX + 1);
  localparam int RW = LMAX + 1;

  vsbc_ctrl_state_e state_q, state_d;

  logic [LW-1:0] len_q;
  logic [LW-1:0] len_clamp;
  logic [W-1:0]  k_q;
  logic [RW-1:0] idx_q;
  logic [RW-1:0] n_m1;
  logic          clr_n_q;
  logic          vsbc_rst_n;
  logic          beat_acc;
  logic          et_hit;
  logic          z_in;
  logic          rshift;
  logic [TW-1:0] bz;

  logic          done_q;
  logic [TW-1:0] result_q;
  logic [RW-1:0] res_len_q;
  logic          err_q;

  assign len_clamp = (bus.len_log2 > LW'(LMAX)) ? LW'(LMAX) : bus.len_log2;
  assign n_m1      = (RW'(1) << len_q) - RW'(1);
  assign beat_acc  = (state_q == ST_RUN) && bus.z_valid;

`ifdef VSBC_CTRL_ET_EN
  assign et_hit = bus.z_last;
`else
  assign et_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the Z/rshift drive into vsbc; idle cycles are no-ops.
  always_comb begin
    state_d = state_q;
    z_in    = 1'b0;
    rshift  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (beat_acc) begin
          z_in   = bus.z;
          rshift = is_pow2(16'(idx_q));
          if ((idx_q == n_m1) || et_hit) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        rshift  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run parameters latched at start and the beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      k_q   <= '0;
      idx_q <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.start) begin
        len_q <= len_clamp;
        k_q   <= bus.k_init;
      end
      if (state_q == ST_CLEAR) idx_q <= '0;
      else if (beat_acc)       idx_q <= idx_q + RW'(1);
    end
  end

  // Registered clear, low exactly during the CLEAR cycle so vsbc sees a glitch-free reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_n_q <= 1'b1;
    else        clr_n_q <= (state_d != ST_CLEAR);
  end

  assign vsbc_rst_n = rst_n & clr_n_q;

  // Result capture; done pulses the cycle after DONE, as the FSM reaches IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      result_q  <= '0;
      res_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        result_q  <= bz;
        res_len_q <= idx_q;
`ifdef VSBC_CTRL_ET_EN
        err_q     <= ~is_pow2(16'(idx_q));
`else
        err_q     <= 1'b0;
`endif
      end
    end
  end

  assign bus.z_ready = (state_q == ST_RUN);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.res_len = res_len_q;
  assign bus.err     = err_q;

  vsbc #(
    .W  (W),
    .TW (TW)
  ) u_vsbc (
    .clk    (clk),
    .rst_n  (vsbc_rst_n),
    .k_init (k_q),
    .z      (z_in),
    .rshift (rshift),
    .bz     (bz)
  );
endmodule
